// File: rtl/unsign_multu.sv
// ---------------------------------------------------------------------------
// unsign_multu
//   Sequential unsigned shift-add multiplier. One multiplier bit is consumed
//   per clock. It shares the enable/busy handshake of the iterative divider,
//   so issue logic can drive both units the same way.
//
//   Handshake: a start request is taken when enable is high on a rising edge
//   of clk_in while busy is low. The operand word is captured on that edge,
//   so the source does not have to hold it. enable while busy is ignored.
//   Completion drives done high for exactly one cycle, with out_data updated
//   and busy low in that same cycle. A new enable may be taken in that cycle.
//
//   Optional feature: define MULTU_EARLY_EXIT_EN to end a run as soon as the
//   remaining multiplier bits are all zero. The product is unchanged. When
//   the macro is undefined, latency is always WIDTH cycles.
//
// Parameters
//   WIDTH        operand width (>= 2); the product is 2*WIDTH bits
// Ports
//   clk_in       clock, rising edge
//   reset        asynchronous reset, active low
//   input_data   [2W-1:W] multiplicand A, [W-1:0] multiplier B
//   enable       start request
//   out_data     last completed product A*B
//   busy         high while a multiplication is running
//   done         one-cycle pulse when out_data takes a new product
//   dbg_state_o  current FSM state (0 = IDLE, 1 = RUN)
// ---------------------------------------------------------------------------
module unsign_multu #(
  parameter int WIDTH = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] input_data,
  input  logic               enable,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy,
  output logic               done,
  output logic [0:0]         dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic               done_q, done_d;

  // One shift-add step of the datapath, computed every cycle.
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      count_step;
  logic               finish;
  logic [2*WIDTH-1:0] result;

`ifdef MULTU_EARLY_EXIT_EN
  logic [WIDTH-1:0]   mult_rem;
  logic               early;
`endif

  always_comb begin
    // The carry out of the W-bit add is kept. It becomes the MSB after the
    // shift, which is why (2^W-1)^2 fits with no overflow.
    sum        = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_step   = {sum, acc_q[WIDTH-1:1]};
    count_step = count_q + CNT_ONE;
`ifdef MULTU_EARLY_EXIT_EN
    // After count_step steps, the low (WIDTH - count_step) bits of acc_step
    // are the multiplier bits that have not been used yet. If they are all
    // zero, the remaining steps only shift right. That shift is done here in
    // one go.
    mult_rem   = acc_step[WIDTH-1:0] & ({WIDTH{1'b1}} >> count_step);
    early      = (mult_rem == {WIDTH{1'b0}});
    finish     = (count_step == CNT_LAST) || early;
    result     = acc_step >> (CNT_LAST - count_step);
`else
    finish     = (count_step == CNT_LAST);
    result     = acc_step;
`endif
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    count_d = count_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          mcand_d = input_data[2*WIDTH-1:WIDTH];
          acc_d   = {{WIDTH{1'b0}}, input_data[WIDTH-1:0]};
          count_d = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = acc_step;
        count_d = count_step;
        if (finish) begin
          out_d   = result;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign out_data    = out_q;
  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
